// File: rtl/tick_pulse_gen.sv
// rtl/tick_pulse_gen.sv - selected divider tap to single-cycle tick enables with run/pause/single-step
// Optional feature macro: TICK_PULSE_COUNT_EN (builds the tick_count register; otherwise tied to 0).

module tick_pulse_gen #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk_src,
  input  logic             rst,
  input  logic [WIDTH-1:0] clk_group,
  input  logic [SEL_W-1:0] sel,
  input  logic             run,
  input  logic             step_req,
  output logic             tick,
  output logic             step_ack,
  output logic [CNT_W-1:0] tick_count,
  output logic [1:0]       state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;

  logic             tap;
  logic             tap_q;
  logic [SEL_W-1:0] sel_q;
  logic             armed;
  logic             rise;
  logic [1:0]       state_n;
  logic             tick_n;
  logic             ack_n;
  logic             armed_n;

  // Tap mux; out-of-range selects clamp to the slowest tap (top bit).
  always_comb begin
    tap = clk_group[WIDTH-1];
    for (int i = 0; i < WIDTH; i++) begin
      if (sel == SEL_W'(i)) tap = clk_group[i];
    end
  end

  // A select change masks the edge so tap switching cannot fake a rise.
  assign rise = tap & ~tap_q & (sel == sel_q);

  // Next-state, tick and acknowledge decisions.
  always_comb begin
    state_n = state;
    tick_n  = 1'b0;
    ack_n   = 1'b0;
    armed_n = armed | ~step_req;
    case (state)
      ST_IDLE: begin
        if (run) begin
          state_n = ST_RUN;
        end else if (step_req && armed) begin
          state_n = ST_STEP;
        end
      end
      ST_RUN: begin
        if (!run) begin
          state_n = ST_IDLE;
        end else begin
          tick_n = rise;
        end
      end
      ST_STEP: begin
        if (run) begin
          state_n = ST_RUN;
          tick_n  = rise;
        end else if (rise) begin
          tick_n  = 1'b1;
          ack_n   = 1'b1;
          armed_n = 1'b0;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Edge-detect history, FSM state and registered outputs.
  always_ff @(posedge clk_src or posedge rst) begin
    if (rst) begin
      tap_q    <= 1'b0;
      sel_q    <= '0;
      state    <= ST_IDLE;
      armed    <= 1'b1;
      tick     <= 1'b0;
      step_ack <= 1'b0;
    end else begin
      tap_q    <= tap;
      sel_q    <= sel;
      state    <= state_n;
      armed    <= armed_n;
      tick     <= tick_n;
      step_ack <= ack_n;
    end
  end

`ifdef TICK_PULSE_COUNT_EN
  // Count emitted ticks; new value lands on the same edge as the tick.
  always_ff @(posedge clk_src or posedge rst) begin
    if (rst) begin
      tick_count <= '0;
    end else if (tick_n) begin
      tick_count <= tick_count + 1'b1;
    end
  end
`else
  assign tick_count = '0;
`endif

endmodule

// File: tb/tb_tick_pulse_gen.sv
// tb/tb_tick_pulse_gen.sv - self-checking bench for tick_pulse_gen against a behavioural model

module tb_tick_pulse_gen;

  localparam int W  = 8;
  localparam int SW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  grp = '0;
  logic [SW-1:0] b_sel = '0;
  logic          b_run = 1'b0;
  logic          b_step = 1'b0;
  logic          tick;
  logic          step_ack;
  logic [CW-1:0] tick_count;
  logic [1:0]    state;

  int n_checks = 0;
  int n_fail = 0;

  // model state, described in terms of the behaviour rules
  int m_prev_tap, m_prev_sel, m_mode, m_armed, m_count;
  int e_tick, e_ack;
  int ci;

  always #5 clk = ~clk;

  tick_pulse_gen #(.WIDTH(W), .SEL_W(SW), .CNT_W(CW)) dut (
    .clk_src(clk), .rst(rst), .clk_group(grp), .sel(b_sel), .run(b_run),
    .step_req(b_step), .tick(tick), .step_ack(step_ack),
    .tick_count(tick_count), .state(state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int exp_count();
`ifdef TICK_PULSE_COUNT_EN
    return m_count;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_prev_tap = 0; m_prev_sel = 0; m_mode = 0; m_armed = 1; m_count = 0;
    e_tick = 0; e_ack = 0;
  endtask

  // Decide what the next edge should produce from the current inputs.
  task automatic model_step();
    int idx, tapv, edge_seen;
    idx = (int'(b_sel) > W - 1) ? W - 1 : int'(b_sel);
    tapv = int'(grp[idx]);
    edge_seen = (tapv == 1 && m_prev_tap == 0 && int'(b_sel) == m_prev_sel) ? 1 : 0;
    e_tick = 0; e_ack = 0;
    if (m_mode == 0) begin
      if (b_run) m_mode = 1;
      else if (b_step && m_armed == 1) m_mode = 2;
    end else if (m_mode == 1) begin
      if (!b_run) m_mode = 0;
      else e_tick = edge_seen;
    end else begin
      if (b_run) begin
        m_mode = 1; e_tick = edge_seen;
      end else if (edge_seen == 1) begin
        e_tick = 1; e_ack = 1; m_armed = 0; m_mode = 0;
      end
    end
    if (!b_step) m_armed = 1;
    if (e_tick == 1) m_count = (m_count + 1) % (1 << CW);
    m_prev_tap = tapv;
    m_prev_sel = int'(b_sel);
  endtask

  task automatic do_cycle();
    model_step();
    @(posedge clk); #1;
    check("tick", tick, e_tick);
    check("step_ack", step_ack, e_ack);
    check("state", state, m_mode);
    check("tick_count", tick_count, exp_count());
    grp = grp + 1'b1;
    ci++;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("rst_tick", tick, 0);
    check("rst_ack", step_ack, 0);
    check("rst_count", tick_count, 0);
    check("rst_state", state, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nt, na, nb, last, first;
    int acked;
    model_reset();
    @(posedge clk); #1;
    apply_reset();

    // free-run sel=2 from reset with divider starting at 0
    grp = '0; b_sel = 4'd2; b_run = 1'b1; ci = 0; nt = 0; last = -1; first = -1;
    while (nt < 10 && ci < 200) begin
      do_cycle();
      if (tick) begin
        if (nt == 0) begin
          first = ci - 1;
          check("d1_first", first, 4);
        end else begin
          check("d1_period", (ci - 1) - last, 8);
        end
        last = ci - 1;
        nt++;
      end
    end
    check("d1_ticks", nt, 10);
`ifdef TICK_PULSE_COUNT_EN
    check("d1_count10", tick_count, 10);
`else
    check("d1_count10", tick_count, 0);
`endif

    // switch to sel=0 on the cycle bit 0 rises
    for (int i = 0; i < 4 && grp[0] == 1'b0; i++) do_cycle();
    b_sel = 4'd0;
    do_cycle();
    check("sel_switch_mask", tick, 0);
    nt = 0;
    for (int i = 0; i < 8; i++) begin
      do_cycle();
      if (tick) nt++;
    end
    check("sel0_ticks", nt, 4);

    // single step with a held request, then a re-armed second step
    b_run = 1'b0;
    for (int i = 0; i < 3; i++) do_cycle();
    b_sel = 4'd3;
    for (int i = 0; i < 2; i++) do_cycle();
    for (int rep = 0; rep < 2; rep++) begin
      b_step = 1'b1; nt = 0; na = 0; nb = 0;
      for (int i = 0; i < 40; i++) begin
        do_cycle();
        if (tick) nt++;
        if (step_ack) na++;
        if (tick && step_ack) nb++;
      end
      check("step_ticks", nt, 1);
      check("step_acks", na, 1);
      check("step_same_cycle", nb, 1);
      b_step = 1'b0;
      do_cycle();
    end

    // run and step together: run wins, never an ack
    b_run = 1'b1; b_step = 1'b1; nt = 0; na = 0;
    for (int i = 0; i < 40; i++) begin
      do_cycle();
      if (tick) nt++;
      if (step_ack) na++;
    end
    check("both_no_ack", na, 0);
    check("both_ticks_ge2", (nt >= 2) ? 1 : 0, 1);
    check("both_state_run", state, 1);
    b_step = 1'b0; b_run = 1'b0;
    do_cycle();

    // counter wrap with sel=0
    apply_reset();
    b_sel = 4'd0; b_run = 1'b1; nt = 0; ci = 0;
    while (nt < 17 && ci < 100) begin
      do_cycle();
      if (tick) nt++;
    end
    check("wrap_ticks", nt, 17);
`ifdef TICK_PULSE_COUNT_EN
    check("wrap_count", tick_count, 1);
`else
    check("wrap_count", tick_count, 0);
`endif

    // reset lands one cycle before the step's rise
    b_run = 1'b0; b_step = 1'b0; b_sel = 4'd3;
    for (int i = 0; i < 20 && grp[3:0] != 4'd9; i++) do_cycle();
    b_step = 1'b1;
    for (int i = 0; i < 20 && grp[3:0] != 4'd7; i++) do_cycle();
    check("pre_rst_state_step", state, 2);
    b_step = 1'b0;
    apply_reset();
    nt = 0; na = 0;
    for (int i = 0; i < 20; i++) begin
      do_cycle();
      if (tick) nt++;
      if (step_ack) na++;
    end
    check("rst_step_no_tick", nt, 0);
    check("rst_step_no_ack", na, 0);
    check("rst_step_idle", state, 0);

    // randomized run/step/select traffic
    acked = 0;
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 19) == 0) b_run = ~b_run;
      if ($urandom_range(0, 29) == 0) b_sel = SW'($urandom_range(0, 15));
      if (b_step && acked == 1) b_step = 1'b0;
      else if (!b_step && $urandom_range(0, 7) == 0) b_step = 1'b1;
      do_cycle();
      acked = step_ack ? 1 : 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
